// File: rtl/fir_mac_sequencer_if.sv
// Sample/result handshake and coefficient-write bus for fir_mac_sequencer.
// dbg_state mirrors the sequencer FSM (0 = IDLE, 1 = MAC, 2 = OUT).
interface fir_mac_sequencer_if #(
  parameter int WL = 32
);
  logic [WL-1:0] xin;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] yout;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [WL-1:0] coef_wdata;
  logic [1:0]    dbg_state;

  // Handshakes: a transfer happens at a rising edge where valid && ready;
  // yout is held stable while out_valid is high and out_ready is low.
  modport master (
    output xin, in_valid, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, yout, out_valid, busy, dbg_state
  );

  modport slave (
    input  xin, in_valid, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, yout, out_valid, busy, dbg_state
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// 3-tap FIR using one shared multiply-accumulate, sequenced over three cycles.
// Define FIR_COEF_WR_EN to make coefficients writable while IDLE.
module fir_mac_sequencer #(
  parameter int WL = 32,
  parameter int H0 = -3,
  parameter int H1 = 3,
  parameter int H2 = 5
) (
  input logic                  CLK,
  input logic                  rst,
  fir_mac_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic signed [WL-1:0] H0_W = WL'(H0);
  localparam logic signed [WL-1:0] H1_W = WL'(H1);
  localparam logic signed [WL-1:0] H2_W = WL'(H2);

  state_t state, state_nx;
  logic signed [WL-1:0] x0, x1, x2;
  logic signed [WL-1:0] c0, c1, c2;
  logic signed [WL-1:0] acc, yout_q;
  logic signed [WL-1:0] c_sel, x_sel, prod, sum;
  logic [1:0] tap;
  logic in_hs, out_hs;

  always_comb begin
    in_hs    = (state == S_IDLE) && bus.in_valid;
    out_hs   = (state == S_OUT) && bus.out_ready;
    state_nx = state;
    case (state)
      S_IDLE:  if (in_hs) state_nx = S_MAC;
      S_MAC:   if (tap == 2'd2) state_nx = S_OUT;
      S_OUT:   if (out_hs) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Products and sums wrap to WL bits; no saturation.
  always_comb begin
    c_sel = c2;
    x_sel = x2;
    case (tap)
      2'd0:    begin c_sel = c0; x_sel = x0; end
      2'd1:    begin c_sel = c1; x_sel = x1; end
      default: begin c_sel = c2; x_sel = x2; end
    endcase
    prod = c_sel * x_sel;
    sum  = acc + prod;
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state  <= S_IDLE;
      x0     <= '0;
      x1     <= '0;
      x2     <= '0;
      acc    <= '0;
      tap    <= '0;
      yout_q <= '0;
    end else begin
      state <= state_nx;
      if (in_hs) begin
        x2  <= x1;
        x1  <= x0;
        x0  <= bus.xin;
        acc <= '0;
        tap <= '0;
      end else if (state == S_MAC) begin
        acc <= sum;
        if (tap == 2'd2) begin
          tap    <= '0;
          yout_q <= sum;
        end else begin
          tap <= tap + 2'd1;
        end
      end
    end
  end

`ifdef FIR_COEF_WR_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      c0 <= H0_W;
      c1 <= H1_W;
      c2 <= H2_W;
    end else if ((state == S_IDLE) && bus.coef_we) begin
      case (bus.coef_addr)
        2'd0:    c0 <= bus.coef_wdata;
        2'd1:    c1 <= bus.coef_wdata;
        2'd2:    c2 <= bus.coef_wdata;
        default: ;
      endcase
    end
  end
`else
  assign c0 = H0_W;
  assign c1 = H1_W;
  assign c2 = H2_W;

  // Write port is kept for pin compatibility but has no effect in this build.
  logic unused_coef;
  assign unused_coef = ^{bus.coef_we, bus.coef_addr, bus.coef_wdata};
`endif

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign bus.busy      = (state != S_IDLE);
  assign bus.yout      = yout_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: impulse, step, backpressure, wrap,
// mid-MAC reset and coefficient writes (FIR_COEF_WR_EN selects which behaviour).
module tb_fir_mac_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   lat_cnt;
  logic [31:0] exp_q[$];

  fir_mac_sequencer_if #(.WL(32)) bus ();

  fir_mac_sequencer #(.WL(32), .H0(-3), .H1(3), .H2(5)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_yout", bus.yout, 32'd0);
    check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
  endtask

  // Returns at the first falling edge after the input handshake edge.
  task automatic send(input logic [31:0] x);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.xin      = x;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.xin      = 32'd0;
    lat_cnt      = 1;
    check("mac_busy", {31'd0, bus.busy}, 32'd1);
    check("mac_in_ready", {31'd0, bus.in_ready}, 32'd0);
  endtask

  // Result must appear at the 4th falling edge after the handshake edge.
  task automatic expect_out(input int hold);
    logic [31:0] exp;
    while (!bus.out_valid && lat_cnt < 20) begin
      @(negedge clk);
      lat_cnt++;
    end
    check("latency", lat_cnt, 32'd4);
    exp = exp_q.pop_front();
    check("yout", bus.yout, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_yout", bus.yout, exp);
      check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("post_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_yout_hold", bus.yout, exp);
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] exp);
    exp_q.push_back(exp);
    send(x);
    expect_out(0);
  endtask

  task automatic coef_write(input logic [1:0] addr, input logic [31:0] data);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = addr;
    bus.coef_wdata = data;
    @(negedge clk);
    bus.coef_we    = 1'b0;
  endtask

  initial begin
    int ov_cnt;
    n_checks       = 0;
    n_fail         = 0;
    lat_cnt        = 0;
    rst            = 1'b1;
    bus.xin        = 32'd0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = 2'd0;
    bus.coef_wdata = 32'd0;

    // impulse
    do_reset();
    run(32'd1, 32'hFFFF_FFFD);
    run(32'd0, 32'd3);
    // idle with in_valid low must leave the delay line alone
    repeat (5) @(negedge clk);
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    run(32'd0, 32'd5);
    run(32'd0, 32'd0);

    // step
    do_reset();
    run(32'd2, 32'hFFFF_FFFA);
    run(32'd2, 32'd0);
    run(32'd2, 32'd10);

    // backpressure: delay line now 2,2,2; xin=1 -> -3+6+10 = 13
    bus.out_ready = 1'b0;
    exp_q.push_back(32'd13);
    send(32'd1);
    expect_out(10);

    // wrap
    do_reset();
    run(32'h7FFF_FFFF, 32'h8000_0003);

    // reset during the second MAC cycle
    do_reset();
    run(32'd7, 32'hFFFF_FFEB);
    send(32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) ov_cnt++;
    end
    check("midmac_no_out", ov_cnt, 32'd0);
    check("midmac_yout", bus.yout, 32'd0);
    run(32'd1, 32'hFFFF_FFFD);

    // coefficient writes
    do_reset();
    coef_write(2'd0, 32'd7);
    coef_write(2'd3, 32'd99);
`ifdef FIR_COEF_WR_EN
    exp_q.push_back(32'd7);
`else
    exp_q.push_back(32'hFFFF_FFFD);
`endif
    send(32'd1);
    coef_write(2'd1, 32'd100);
    lat_cnt++;
    expect_out(0);
    run(32'd0, 32'd3);
    run(32'd0, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter WL, default 32: data, coefficient and accumulator width in bits.
REQ-002 SHALL have parameter H0, default -3: reset value of tap-0 coefficient, applied to the newest sample.
REQ-003 SHALL have parameter H1, default 3: reset value of tap-1 coefficient.
REQ-004 SHALL have parameter H2, default 5: reset value of tap-2 coefficient, applied to the oldest sample.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port xin, input, WL bits: input sample, two's complement.
REQ-008 SHALL have port in_valid, input, 1 bit: xin is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-010 SHALL have port yout, output, WL bits: filter result, two's complement.
REQ-011 SHALL have port out_valid, output, 1 bit: yout is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream stage accepts yout.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-014 SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-015 SHALL have port coef_addr, input, 2 bits: coefficient index (0..2).
REQ-016 SHALL have port coef_wdata, input, WL bits: coefficient write value.

Function
REQ-017 SHALL compute y = C0*x0 + C1*x1 + C2*x2 using one shared multiply-accumulate, where x0 is the newest accepted sample and x2 the oldest.
REQ-018 SHALL use a three-state FSM: IDLE -> MAC on an input handshake; MAC -> OUT after the tap-2 cycle; OUT -> IDLE on an output handshake.
REQ-019 SHALL drive in_ready high only in IDLE; an input handshake is in_valid && in_ready at a rising edge.
REQ-020 On an input handshake, SHALL shift the delay line (x2 <= x1, x1 <= x0, x0 <= xin), clear the accumulator and set the tap counter to 0.
REQ-021 In MAC, SHALL perform acc <= acc + C[tap]*x[tap] for tap = 0, 1, 2 on three consecutive cycles.
REQ-022 SHALL use signed arithmetic and keep the low WL bits of every product and sum (two's-complement wrap); no saturation.
REQ-023 On the MAC-to-OUT transition, SHALL register the final sum into yout.
REQ-024 SHALL assert out_valid only in OUT; yout SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 Latency: for a sample accepted at edge N, SHALL present yout with out_valid high in the cycle after edge N+3.
REQ-026 Throughput: with out_ready held high, SHALL accept at most one sample every 5 cycles.
REQ-027 When in_valid is low in IDLE, SHALL remain idle with the delay line unchanged; in_valid has no effect outside IDLE.
REQ-028 SHALL keep yout at its last value after the OUT handshake until the next OUT load.

Reset
REQ-029 When rst is high at an edge, SHALL enter IDLE, clear x0..x2, the accumulator, the tap counter and yout to 0, and drive out_valid = 0 and busy = 0.
REQ-030 On reset, SHALL reload C0..C2 from H0..H2.
REQ-031 A reset in MAC or OUT SHALL abandon the in-flight result, with no out_valid pulse.
REQ-032 SHALL drive in_ready high in the cycle after reset deasserts.

Configuration
REQ-033 With macro FIR_COEF_WR_EN defined: coef_we high at an edge while in IDLE SHALL write coef_wdata to C[coef_addr], taking effect from the next cycle.
REQ-034 With FIR_COEF_WR_EN defined: writes outside IDLE, or with coef_addr = 3, SHALL be ignored.
REQ-035 Without FIR_COEF_WR_EN: coefficients SHALL be the constants H0..H2; coef_we, coef_addr and coef_wdata SHALL remain as ports and be ignored.

Verification
REQ-036 Impulse: xin = 1, 0, 0, 0 with out_ready = 1 -> yout = -3, 3, 5, 0.
REQ-037 Step: xin = 2, 2, 2 -> yout = -6, 0, 10.
REQ-038 Backpressure: hold out_ready = 0 for 10 cycles in OUT -> yout stable, out_valid = 1, in_ready = 0 throughout; one handshake on release, then IDLE.
REQ-039 Wrap: first sample xin = 0x7FFFFFFF after reset -> yout = 0x80000003.
REQ-040 Reset mid-MAC: assert rst during the second MAC cycle -> no out_valid pulse; then xin = 1 -> yout = -3, confirming a cleared delay line.
REQ-041 With FIR_COEF_WR_EN: write C0 = 7 in IDLE, then impulse -> first yout = 7; a write attempted during MAC leaves the coefficients unchanged.
